// File: rtl/instr_fetch_stage.sv
// Instruction fetch + IF/ID register: PC, req/ack instruction-memory port,
// one-entry skid buffer for downstream stall, and branch redirect with flush-to-NOP.
module instr_fetch_stage #(
   parameter int unsigned          ADDR_W   = 16,
   parameter int unsigned          INSTR_W  = 32,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   output logic                 IMEM_REQ,
   output logic [ADDR_W-1:0]    IMEM_ADDR,
   input  logic                 IMEM_ACK,
   input  logic [INSTR_W-1:0]   IMEM_RDATA,
   input  logic                 STALL,
   input  logic                 SALTO,
   input  logic [ADDR_W-1:0]    BR_TARGET,
   output logic                 ID_VALID,
   output logic [3:0]           OpCode,
   output logic [1:0]           F,
   output logic [3:0]           RD,
   output logic [3:0]           RS1,
   output logic [3:0]           RS2,
   output logic [13:0]          IMM,
   output logic [ADDR_W-1:0]    ID_PC
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [5:0]         NOP_OPF  = 6'b000011;
   localparam logic [INSTR_W-1:0] NOP_WORD = {NOP_OPF, {(INSTR_W-6){1'b0}}};

   logic [1:0]          r_rst_sync;
   logic                w_rst_n;
   state_t              r_state;
   logic                r_req;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   r_target;
   logic [ADDR_W-1:0]   r_skid_pc;
   logic [INSTR_W-1:0]  r_skid_word;
   logic                r_id_valid;
   logic [ADDR_W-1:0]   r_id_pc;
   logic [INSTR_W-1:0]  r_id_word;
   logic                w_ack;
   logic                w_id_free;
   logic [ADDR_W-1:0]   w_pc_inc;

   // Reset asserts asynchronously but releases on a clock edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_rst_sync <= '0;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_ack     = IMEM_ACK & r_req;
   assign w_id_free = ~r_id_valid | ~STALL;
   assign w_pc_inc  = r_pc + ADDR_W'(1);

   always_ff @(posedge CLK or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state     <= S_FETCH;
         r_req       <= 1'b0;
         r_pc        <= RESET_PC;
         r_target    <= '0;
         r_skid_pc   <= '0;
         r_skid_word <= '0;
         r_id_valid  <= 1'b0;
         r_id_pc     <= '0;
         r_id_word   <= NOP_WORD;
      end else if (SALTO) begin
         r_id_valid                 <= 1'b0;
         r_id_word[INSTR_W-1 -: 6]  <= NOP_OPF;
         r_skid_word                <= '0;
         r_skid_pc                  <= '0;
         if (w_ack || !r_req) begin
            r_pc    <= BR_TARGET;
            r_state <= S_FETCH;
            r_req   <= 1'b1;
         end else begin
            // Request still open: keep address stable and drain it first.
            r_target <= BR_TARGET;
            r_state  <= S_DRAIN;
         end
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_ack) begin
                  r_pc <= w_pc_inc;
                  if (w_id_free) begin
                     r_id_word  <= IMEM_RDATA;
                     r_id_pc    <= r_pc;
                     r_id_valid <= 1'b1;
                  end else begin
                     r_skid_word <= IMEM_RDATA;
                     r_skid_pc   <= r_pc;
                     r_state     <= S_HOLD;
                     r_req       <= 1'b0;
                  end
               end else begin
                  r_req <= 1'b1;
                  if (w_id_free) r_id_valid <= 1'b0;
               end
            end
            S_HOLD: begin
               if (w_id_free) begin
                  r_id_word   <= r_skid_word;
                  r_id_pc     <= r_skid_pc;
                  r_id_valid  <= 1'b1;
                  r_skid_word <= '0;
                  r_skid_pc   <= '0;
                  r_state     <= S_FETCH;
                  r_req       <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (w_id_free) r_id_valid <= 1'b0;
               if (w_ack) begin
                  r_pc    <= r_target;
                  r_state <= S_FETCH;
               end
            end
            default: begin
               r_state <= S_FETCH;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   assign IMEM_REQ  = r_req;
   assign IMEM_ADDR = r_pc;
   assign ID_VALID  = r_id_valid;
   assign ID_PC     = r_id_pc;
   assign OpCode    = r_id_word[31:28];
   assign F         = r_id_word[27:26];
   assign RD        = r_id_word[25:22];
   assign RS1       = r_id_word[21:18];
   assign RS2       = r_id_word[17:14];
   assign IMM       = r_id_word[13:0];

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
Instruction fetch and IF/ID register stage directly upstream of the control unit.
- Holds the program counter and issues word reads to instruction memory over a req/ack handshake.
- Splits the returned word into OpCode, F and operand fields, and presents them registered to the control unit and register file.
- Handles stall from downstream and branch redirect (SALTO) with flush-to-NOP.

Parameters:
ADDR_W, 16, PC / instruction-memory word-address width.
INSTR_W, 32, instruction word width; fixed field layout below requires exactly 32.
RESET_PC, 0, PC value loaded on reset.

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
IMEM_REQ  out  1  read request to instruction memory.
IMEM_ADDR  out  ADDR_W  word address of the request.
IMEM_ACK  in  1  read complete; IMEM_RDATA valid in the same cycle.
IMEM_RDATA  in  INSTR_W  instruction word.
STALL  in  1  downstream cannot accept a new instruction this cycle.
SALTO  in  1  branch taken; one-cycle pulse from execute.
BR_TARGET  in  ADDR_W  branch target, valid with SALTO.
ID_VALID  out  1  ID outputs hold a live instruction.
OpCode  out  4  instruction bits [31:28].
F  out  2  instruction bits [27:26].
RD  out  4  bits [25:22].
RS1  out  4  bits [21:18].
RS2  out  4  bits [17:14].
IMM  out  14  bits [13:0], raw (extension is done downstream under SEL_EXT).
ID_PC  out  ADDR_W  address of the instruction in ID.

Behaviour:
Reset (async assert, sync release):
- PC=RESET_PC; state=FETCH; IMEM_REQ=0; IMEM_ADDR=RESET_PC.
- ID_VALID=0; OpCode=4'b0000, F=2'b11 (NOP encoding); RD/RS1/RS2/IMM=0; ID_PC=0.
- Skid buffer empty.
- Reset mid-transaction abandons any outstanding request; memory must tolerate this.

Handshake:
- Once IMEM_REQ is high, IMEM_REQ and IMEM_ADDR stay stable until the cycle IMEM_ACK=1 is sampled.
- IMEM_ACK while IMEM_REQ=0 is ignored.
- Zero-wait memory (ACK every cycle) gives one instruction per cycle.

ID register update (ID "free" = !ID_VALID | !STALL):
- While ID is held (ID_VALID & STALL), all ID outputs stay constant.
- If ID is free and no new word is available, ID_VALID goes 0. The data fields keep their last values.

States:
- FETCH:
  - IMEM_REQ=1, IMEM_ADDR=PC.
  - On ACK with ID free: load ID fields, ID_VALID=1, ID_PC=PC, PC<=PC+1. Stay in FETCH.
  - On ACK with ID not free: capture word and PC into skid buffer, PC<=PC+1, go to HOLD.
- HOLD:
  - IMEM_REQ=0.
  - When ID becomes free: move skid buffer into ID, go to FETCH. New request issues the following cycle.
- DRAIN:
  - IMEM_REQ=1 held at the old address until ACK. Returned data is discarded.
  - Then go to FETCH with PC=redirect address.

SALTO (overrides STALL and all other activity):
- Next cycle: ID_VALID=0, OpCode=0000, F=11; skid buffer cleared.
- If no request is outstanding, or ACK arrives in the same cycle as SALTO: PC<=BR_TARGET, state=FETCH, data discarded.
- If a request is outstanding without ACK: latch BR_TARGET, go to DRAIN.
- SALTO while in DRAIN: the newer BR_TARGET replaces the latched target.

Arithmetic:
- PC+1 is modulo 2^ADDR_W; PC wraps from all-ones to 0 with no flag.

Latency:
- Request at cycle t with ACK at t gives ID valid at t+1.

Test Plan:
1. Reset, RESET_PC=0, ACK tied 1, RDATA=addr-encoded words -> IMEM_ADDR 0,1,2,3 on consecutive cycles; ID_VALID=1 from the 2nd cycle; ID_PC lags IMEM_ADDR by 1; OpCode/F/RD/RS1/RS2/IMM match the bit slices.
2. ACK delayed 3 cycles at addr 5 -> IMEM_REQ/IMEM_ADDR=5 stable 3 cycles; ID_VALID=0 during the wait; instruction appears with ID_PC=5 one cycle after ACK.
3. STALL held 4 cycles with a word in flight -> ID outputs constant; word lands in the skid buffer; IMEM_REQ=0 in HOLD; after STALL drops, instructions appear in order with none lost or duplicated.
4. SALTO with BR_TARGET=0x0040 while idle / with same-cycle ACK / with outstanding request (ACK 2 cycles later) -> ID flushed to NOP (0000/11, ID_VALID=0); in the outstanding case the late data is discarded; the next IMEM_ADDR is 0x0040 in all three cases.
5. PC=0xFFFF, zero-wait memory -> next IMEM_ADDR=0x0000; ID_PC sequence 0xFFFF, 0x0000.
6. RST_N asserted mid-DRAIN and mid-HOLD -> outputs at reset values immediately (asynchronous); fetch restarts at RESET_PC after release.
